tt_um_prbs_chk_danielzhu: RTL and testbench

TT_UM_PRBS_CHK_DANIELZHU -- requirements
Module: tt_um_prbs_chk_danielzhu

---
 rtl/prbs_pkg.sv | 15 +
 rtl/tt_um_prbs_chk_danielzhu_if.sv | 11 +
 rtl/prbs15_step.sv | 11 +
 rtl/tt_um_prbs_chk_danielzhu_core.sv | 129 ++++++++++++
 rtl/tt_um_prbs_chk_danielzhu.sv | 38 +++
 tb/tb_tt_um_prbs_chk_danielzhu.sv | 167 ++++++++++++++++
 6 files changed

// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - PRBS-15 shared definitions for checker and generator
package prbs_pkg;
  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_t;

  localparam int PRBS_W           = 15;
  localparam int TAP_HI           = 14;
  localparam int TAP_LO           = 13;
  localparam int LOCK_MATCHES_DEF = 16;
  localparam int LOSS_ERRORS_DEF  = 8;
  localparam int LOSS_WINDOW_DEF  = 64;
endpackage

// File: rtl/tt_um_prbs_chk_danielzhu_if.sv
// rtl/tt_um_prbs_chk_danielzhu_if.sv - pin bundle between the pad ring and the checker core
interface tt_um_prbs_chk_danielzhu_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/prbs15_step.sv
// rtl/prbs15_step.sv - one step of the x^15+x^14+1 LFSR
module prbs15_step
  import prbs_pkg::*;
(
  input  logic [PRBS_W-1:0] sr,
  output logic              pred,
  output logic [PRBS_W-1:0] sr_next
);
  assign pred    = sr[TAP_HI] ^ sr[TAP_LO];
  assign sr_next = {sr[PRBS_W-2:0], pred};
endmodule

// File: rtl/tt_um_prbs_chk_danielzhu_core.sv
// rtl/tt_um_prbs_chk_danielzhu_core.sv - PRBS-15 acquisition, lock and error counting
module tt_um_prbs_chk_danielzhu_core
  import prbs_pkg::*;
#(
  parameter int LOCK_MATCHES = LOCK_MATCHES_DEF,
  parameter int LOSS_ERRORS  = LOSS_ERRORS_DEF,
  parameter int LOSS_WINDOW  = LOSS_WINDOW_DEF
) (
  input logic                    clk,
  input logic                    rst_n,
  tt_um_prbs_chk_danielzhu_if.slave tt
);
  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int WW = $clog2(LOSS_WINDOW);
  localparam int EW = $clog2(LOSS_ERRORS + 1);

  state_t            state, state_n;
  logic [PRBS_W-1:0] sr, sr_n, sr_step, sr_load;
  logic [3:0]        load_cnt, load_n;
  logic [MW-1:0]     match_cnt, match_n;
  logic [WW-1:0]     win_cnt, win_n;
  logic [EW-1:0]     win_err, win_err_n;
  logic [15:0]       err_cnt, err_n;
  logic              err_pulse, pulse_n;
  logic              pred, bit_in, consume, mismatch, go_search, err_inc;
  logic              unused;

  assign bit_in   = tt.ui_in[0];
  assign consume  = tt.ena & tt.ui_in[1];
  assign mismatch = bit_in ^ pred;
  assign sr_load  = {sr[PRBS_W-2:0], bit_in};
  assign unused   = &{1'b0, tt.ui_in[7:4]};

  prbs15_step u_step (
    .sr      (sr),
    .pred    (pred),
    .sr_next (sr_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      sr        <= '0;
      load_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      load_cnt  <= load_n;
      match_cnt <= match_n;
      win_cnt   <= win_n;
      win_err   <= win_err_n;
      err_cnt   <= err_n;
      err_pulse <= pulse_n;
    end
  end

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    load_n    = load_cnt;
    match_n   = match_cnt;
    win_n     = win_cnt;
    win_err_n = win_err;
    err_n     = err_cnt;
    pulse_n   = err_pulse;
    go_search = 1'b0;
    err_inc   = 1'b0;
    if (tt.ena) pulse_n = 1'b0;
    if (consume) begin
      case (state)
        VERIFY: begin
          sr_n = sr_step;
          if (mismatch) begin
            go_search = 1'b1;
          end else if (match_cnt == MW'(LOCK_MATCHES - 1)) begin
            state_n   = LOCKED;
            win_n     = '0;
            win_err_n = '0;
          end else begin
            match_n = match_cnt + 1'b1;
          end
        end
        LOCKED: begin
          sr_n  = sr_step;
          win_n = win_cnt + 1'b1;
          if (mismatch) begin
            err_inc   = 1'b1;
            pulse_n   = 1'b1;
            win_err_n = win_err + 1'b1;
          end
          // Loss wins over a wrap landing on the same bit.
          if (mismatch && win_err == EW'(LOSS_ERRORS - 1)) go_search = 1'b1;
          else if (win_cnt == WW'(LOSS_WINDOW - 1)) win_err_n = '0;
        end
        default: begin
          state_n = SEARCH;
          sr_n    = sr_load;
          if (load_cnt == 4'd14) begin
            load_n = '0;
            if (sr_load != '0) begin
              state_n = VERIFY;
              match_n = '0;
            end
          end else begin
            load_n = load_cnt + 1'b1;
          end
        end
      endcase
    end
    if (go_search) begin
      state_n   = SEARCH;
      load_n    = '0;
      match_n   = '0;
      win_n     = '0;
      win_err_n = '0;
    end
    if (tt.ena && tt.ui_in[2]) err_n = '0;
    else if (err_inc && err_cnt != 16'hFFFF) err_n = err_cnt + 1'b1;
  end

  assign tt.uo_out  = tt.ui_in[3] ? err_cnt[15:8] : err_cnt[7:0];
  assign tt.uio_out = {4'h0, err_pulse, state == LOCKED, state};
  assign tt.uio_oe  = 8'h0F;
endmodule

// File: rtl/tt_um_prbs_chk_danielzhu.sv
// rtl/tt_um_prbs_chk_danielzhu.sv - TinyTapeout wrapper for the PRBS-15 checker
module tt_um_prbs_chk_danielzhu
  import prbs_pkg::*;
#(
  parameter int LOCK_MATCHES = LOCK_MATCHES_DEF,
  parameter int LOSS_ERRORS  = LOSS_ERRORS_DEF,
  parameter int LOSS_WINDOW  = LOSS_WINDOW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic unused;

  tt_um_prbs_chk_danielzhu_if tt ();

  assign tt.ena   = ena;
  assign tt.ui_in = ui_in;
  assign uo_out   = tt.uo_out;
  assign uio_out  = tt.uio_out;
  assign uio_oe   = tt.uio_oe;
  assign unused   = &{1'b0, uio_in};

  tt_um_prbs_chk_danielzhu_core #(
    .LOCK_MATCHES (LOCK_MATCHES),
    .LOSS_ERRORS  (LOSS_ERRORS),
    .LOSS_WINDOW  (LOSS_WINDOW)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .tt    (tt.slave)
  );
endmodule

// File: tb/tb_tt_um_prbs_chk_danielzhu.sv
// tb/tb_tt_um_prbs_chk_danielzhu.sv - directed checks of the PRBS-15 checker
module tb_tt_um_prbs_chk_danielzhu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  uio_in = 8'h00;
  logic        sel = 1'b0;
  logic [14:0] gen_sr = 15'h7FFF;
  int          checks = 0;
  int          fails = 0;

  tt_um_prbs_chk_danielzhu_if bus ();

  tt_um_prbs_chk_danielzhu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (bus.ena),
    .ui_in   (bus.ui_in),
    .uio_in  (uio_in),
    .uo_out  (bus.uo_out),
    .uio_out (bus.uio_out),
    .uio_oe  (bus.uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic gen(output logic b);
    b = gen_sr[14] ^ gen_sr[13];
    gen_sr = {gen_sr[13:0], b};
  endtask

  task automatic cyc(input logic b, input logic v, input logic c, input logic e);
    bus.ui_in = {4'b0, sel, c, v, b};
    bus.ena   = e;
    @(posedge clk);
    #1;
  endtask

  task automatic good();
    logic b;
    gen(b);
    cyc(b, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic bad(input logic c);
    logic b;
    gen(b);
    cyc(~b, 1'b1, c, 1'b1);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.ena   = 1'b0;
    bus.ui_in = 8'h00;
    #12;
    chk("rst_uo_out", bus.uo_out, 8'h00);
    chk("rst_uio_out", bus.uio_out, 8'h00);
    chk("rst_uio_oe", bus.uio_oe, 8'h0F);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All-zero load must not leave SEARCH
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("zero_load_search", bus.uio_out, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("zero_load_restart", bus.uio_out, 8'h00);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);

    // Clean acquisition: 15 load + 16 matches
    for (int i = 0; i < 15; i++) good();
    chk("load_done_verify", bus.uio_out, 8'h01);
    for (int i = 0; i < 15; i++) good();
    chk("lock_30_not_yet", bus.uio_out, 8'h01);
    good();
    chk("lock_31", bus.uio_out, 8'h06);
    chk("lock_errcnt0", bus.uo_out, 8'h00);

    // Single error
    bad(1'b0);
    chk("err1_pulse", bus.uio_out, 8'h0E);
    chk("err1_count", bus.uo_out, 8'h01);
    good();
    chk("err1_pulse_gone", bus.uio_out, 8'h06);

    // ena low: garbage, clear and valid all ignored
    for (int i = 0; i < 10; i++) cyc(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
    chk("ena0_state", bus.uio_out, 8'h06);
    chk("ena0_count", bus.uo_out, 8'h01);
    good();
    chk("ena_resume", bus.uio_out, 8'h06);
    sel = 1'b1;
    bus.ui_in[3] = 1'b1;
    #1 chk("count_hi_byte", bus.uo_out, 8'h00);
    sel = 1'b0;
    bus.ui_in[3] = 1'b0;
    #1;

    // Clear beats a simultaneous increment
    bad(1'b1);
    chk("clr_vs_err_count", bus.uo_out, 8'h00);
    chk("clr_vs_err_pulse", bus.uio_out, 8'h0E);
    good();

    // Asynchronous reset mid-lock
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_uio_out", bus.uio_out, 8'h00);
    chk("async_rst_uo_out", bus.uo_out, 8'h00);
    chk("async_rst_uio_oe", bus.uio_oe, 8'h0F);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) good();
    chk("post_rst_search", bus.uio_out, 8'h00);
    for (int i = 0; i < 25; i++) good();
    chk("relock_30", bus.uio_out, 8'h01);
    good();
    chk("relock_31", bus.uio_out, 8'h06);

    // Eight errors inside one window force loss of lock
    for (int i = 0; i < 7; i++) bad(1'b0);
    chk("loss_7_locked", bus.uio_out, 8'h0E);
    bad(1'b0);
    chk("loss_8_search", bus.uio_out, 8'h08);
    chk("loss_8_count", bus.uo_out, 8'h08);
    for (int i = 0; i < 30; i++) good();
    chk("loss_relock_30", bus.uio_out, 8'h01);
    good();
    chk("loss_relock_31", bus.uio_out, 8'h06);
    chk("loss_count_kept", bus.uo_out, 8'h08);

    // Window wrap discards the earlier seven errors
    for (int i = 0; i < 7; i++) bad(1'b0);
    for (int i = 0; i < 57; i++) good();
    chk("wrap_locked", bus.uio_out, 8'h06);
    bad(1'b0);
    chk("wrap_err_locked", bus.uio_out, 8'h0E);
    chk("wrap_count", bus.uo_out, 8'h10);

    // Valid on alternate cycles: only consumed bits count toward lock
    pulse_reset();
    for (int i = 0; i < 61; i++) begin
      if (i % 2 == 0) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
      else good();
    end
    chk("half_valid_30", bus.uio_out, 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("half_valid_idle", bus.uio_out, 8'h01);
    good();
    chk("half_valid_31", bus.uio_out, 8'h06);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
